piso_output_fifo: RTL and testbench
===================================

// Module: piso_output_fifo
// PURPOSE
//   Parametrised parallel-in / serial-out output stage for the FP adder result path.
//   Buffers up to DEPTH result words in a FIFO and streams them bit-serially through a shift stage.
//   Supports back-to-back words with no bubble, selectable bit order, a last-bit marker and a flush.
//   Sits between the adder result register and the chip-level serial output pin.
// PARAMETERS
//   WIDTH      32  bits per word (>=2)
//   DEPTH      4   FIFO words, excluding the shift stage (power of 2, >=2)
//   MSB_FIRST  0   0: bit 0 shifted out first; 1: bit WIDTH-1 first
// PORTS
//   clk_in          in   1                    single clock, rising edge
//   rst_in          in   1                    synchronous, active-high reset
//   flush_in        in   1                    sync clear of FIFO + shifter (reset has priority)
//   parallel_in     in   WIDTH                word to enqueue
//   wr_in           in   1                    write request; accepted when wr_in && input_rdy
//   input_rdy       out  1                    FIFO not full
//   output_read_in  in   1                    request one serial bit this cycle
//   output_rdy      out  1                    shifter holds >=1 unsent bit
//   serial_out      out  1                    serial data bit (registered)
//   serial_valid    out  1                    serial_out carries a fresh bit this cycle
//   serial_last     out  1                    serial_out is the final bit of a word
//   fifo_level      out  $clog2(DEPTH+1)      words in FIFO (shifter excluded)
// BEHAVIOUR
//   Reset/flush: FIFO empty, shifter empty, bit count 0; input_rdy=1, output_rdy=0,
//     serial_out=0, serial_valid=0, serial_last=0, fifo_level=0. Mid-word: partial word discarded.
//   input_rdy and output_rdy derive from registered state only (no comb path from wr_in/read_in).
//   Write: on accepted write, word stored at tail at that edge; fifo_level increments.
//     wr_in while input_rdy=0 is ignored, word dropped, no state change.
//   Shifter states: EMPTY -> LOADED on a head pop; LOADED -> EMPTY after WIDTH bits if FIFO empty.
//   Load: in EMPTY with FIFO non-empty, head pops into shifter at next edge (1-cycle latency);
//     write to empty FIFO at edge N -> output_rdy=1 after edge N+1. No write-to-shifter bypass.
//   Shift: on edge with output_read_in && output_rdy: serial_out <= current bit (bit 0 or WIDTH-1
//     per MSB_FIRST), shifter advances, bit count++, serial_valid <= 1; else serial_valid <= 0,
//     serial_out holds its last value.
//   Last bit: when bit count reaches WIDTH-1 on a shift, serial_last <= 1 with that bit;
//     if FIFO non-empty, head pops into shifter on the SAME edge (no gap); else shifter -> EMPTY.
//   Simultaneous write + pop: both happen; fifo_level unchanged; pop of full FIFO with write
//     pending is not a pass-through -- the write waits since input_rdy=0 that cycle.
//   Pointers wrap modulo DEPTH; fifo_level counts 0..DEPTH, full when fifo_level==DEPTH.
//   output_read_in while output_rdy=0: no effect, serial_valid <= 0.
//   flush_in with wr_in same cycle: flush wins, write dropped.
// TESTING
//   1 Reset: hold rst_in 2 cycles mid-stream -> all outputs at reset values, fifo_level=0.
//   2 Write 32'hA5A5_0F0F, MSB_FIRST=0, read held high -> output_rdy 1 cycle after write,
//     32 valid bits 1,1,1,1,0,0,0,0,... serial_last only on 32nd bit, then output_rdy=0.
//   3 MSB_FIRST=1, write 32'h8000_0001 -> first bit 1, bits 2..31 zero, last bit 1.
//   4 Write 5 words (DEPTH=4), read low -> 1 word in shifter, fifo_level=4, input_rdy=0;
//     6th write ignored; 5 words stream out as 160 consecutive valid bits, no gap, 5 serial_last.
//   5 Read toggled every other cycle -> serial_valid only on read cycles, bit order intact.
//   6 flush_in after 10 bits of a word with 2 queued -> next cycle output_rdy=0, fifo_level=0;
//     new write afterwards streams correctly from bit 0.

Source files
------------

// File: rtl/piso_output_fifo_if.sv
// Handshake bundle for the serialiser: parallel word input, flush, serial bit output and status.
// The driver side (adder result path) uses master; the serialiser uses slave.
interface piso_output_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                         flush_in;
  logic [WIDTH-1:0]             parallel_in;
  logic                         wr_in;
  logic                         input_rdy;
  logic                         output_read_in;
  logic                         output_rdy;
  logic                         serial_out;
  logic                         serial_valid;
  logic                         serial_last;
  logic [$clog2(DEPTH+1)-1:0]   fifo_level;

  modport master (
    output flush_in, parallel_in, wr_in, output_read_in,
    input  input_rdy, output_rdy, serial_out, serial_valid, serial_last, fifo_level
  );

  modport slave (
    input  flush_in, parallel_in, wr_in, output_read_in,
    output input_rdy, output_rdy, serial_out, serial_valid, serial_last, fifo_level
  );
endinterface

// File: rtl/piso_output_fifo.sv
// Word FIFO plus shift stage serialising FP adder results bit by bit, back-to-back words with no gap.
// Latency: write to first serial bit is 2 edges; writes are refused (input_rdy=0) while the FIFO is full.

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_rdy,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) mem[wr_ptr] <= push_dat;
  end
endmodule

module piso_output_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  piso_output_fifo_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {SH_EMPTY, SH_LOADED} sh_state_t;

  sh_state_t        state_q;
  sh_state_t        state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] head_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic             do_shift;
  logic             last_shift;
  logic             pop;
  logic             cur_bit;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk_in),
    .rst      (rst_in),
    .clr      (bus.flush_in),
    .push_vld (bus.wr_in),
    .push_dat (bus.parallel_in),
    .pop_rdy  (pop),
    .head_dat (head_dat),
    .level    (bus.fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.input_rdy  = !fifo_full;
  assign bus.output_rdy = (state_q == SH_LOADED);
  assign cur_bit        = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    do_shift   = bus.output_read_in && (state_q == SH_LOADED);
    last_shift = do_shift && (cnt_q == CNT_LAST);
    // refill on the same edge the final bit leaves, so consecutive words have no bubble
    pop        = !fifo_empty && ((state_q == SH_EMPTY) || last_shift);
    if (do_shift) begin
      shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CNT_ONE;
    end
    if (pop) begin
      state_d = SH_LOADED;
      shift_d = head_dat;
      cnt_d   = '0;
    end else if (last_shift) begin
      state_d = SH_EMPTY;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || bus.flush_in) begin
      state_q          <= SH_EMPTY;
      shift_q          <= '0;
      cnt_q            <= '0;
      bus.serial_out   <= 1'b0;
      bus.serial_valid <= 1'b0;
      bus.serial_last  <= 1'b0;
    end else begin
      state_q          <= state_d;
      shift_q          <= shift_d;
      cnt_q            <= cnt_d;
      if (do_shift) bus.serial_out <= cur_bit;
      bus.serial_valid <= do_shift;
      bus.serial_last  <= last_shift;
    end
  end
endmodule

// File: tb/tb_piso_output_fifo.sv
// Bench: LSB-first and MSB-first instances share one stimulus; a queue-based model is checked every cycle.
module tb_piso_output_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             flush;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] din;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk_in = ~clk_in;

  piso_output_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_l ();
  piso_output_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_m ();

  assign bus_l.flush_in = flush;
  assign bus_l.wr_in = wr;
  assign bus_l.parallel_in = din;
  assign bus_l.output_read_in = rd;
  assign bus_m.flush_in = flush;
  assign bus_m.wr_in = wr;
  assign bus_m.parallel_in = din;
  assign bus_m.output_read_in = rd;

  piso_output_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
    .clk_in (clk_in), .rst_in (rst_in), .bus (bus_l)
  );
  piso_output_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
    .clk_in (clk_in), .rst_in (rst_in), .bus (bus_m)
  );

  // model: queue of stored words, the word being sent and how many of its bits have gone
  logic [WIDTH-1:0] m_q [$];
  logic [WIDTH-1:0] m_word;
  int               m_idx;
  bit               m_loaded;
  bit               m_live = 1'b0;
  logic             e_out_l, e_out_m, e_vld, e_last;
  bit               room;

  logic gl_bit [$];
  logic gl_last [$];
  int   gl_cyc [$];
  logic gm_bit [$];
  logic gm_last [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input logic ir, input logic orr, input logic [LW-1:0] lvl,
                     input logic v, input logic l, input logic o, input logic eo);
    chk({tag, "_input_rdy"},    {63'd0, ir},  {63'd0, (m_q.size() < DEPTH)});
    chk({tag, "_output_rdy"},   {63'd0, orr}, {63'd0, m_loaded});
    chk({tag, "_fifo_level"},   64'(lvl),     64'(m_q.size()));
    chk({tag, "_serial_valid"}, {63'd0, v},   {63'd0, e_vld});
    chk({tag, "_serial_last"},  {63'd0, l},   {63'd0, e_last});
    chk({tag, "_serial_out"},   {63'd0, o},   {63'd0, eo});
  endtask

  initial forever begin
    @(posedge clk_in);
    if (rst_in || flush) begin
      m_live = 1'b1;
      m_q.delete();
      m_loaded = 1'b0; m_idx = 0; m_word = '0;
      e_out_l = 1'b0; e_out_m = 1'b0; e_vld = 1'b0; e_last = 1'b0;
    end else if (m_live) begin
      room   = (m_q.size() < DEPTH);
      e_vld  = rd && m_loaded;
      e_last = 1'b0;
      if (e_vld) begin
        e_out_l = m_word[m_idx];
        e_out_m = m_word[WIDTH-1-m_idx];
        e_last  = (m_idx == WIDTH-1);
        m_idx++;
        if (m_idx == WIDTH) m_loaded = 1'b0;
      end
      if (!m_loaded && m_q.size() > 0) begin
        m_word = m_q.pop_front();
        m_idx = 0;
        m_loaded = 1'b1;
      end
      if (wr && room) m_q.push_back(din);
    end
  end

  initial forever begin
    @(negedge clk_in);
    cyc++;
    if (m_live) begin
      cmp("lsb", bus_l.input_rdy, bus_l.output_rdy, bus_l.fifo_level, bus_l.serial_valid,
          bus_l.serial_last, bus_l.serial_out, e_out_l);
      cmp("msb", bus_m.input_rdy, bus_m.output_rdy, bus_m.fifo_level, bus_m.serial_valid,
          bus_m.serial_last, bus_m.serial_out, e_out_m);
    end
    if (bus_l.serial_valid === 1'b1) begin
      gl_bit.push_back(bus_l.serial_out); gl_last.push_back(bus_l.serial_last); gl_cyc.push_back(cyc);
    end
    if (bus_m.serial_valid === 1'b1) begin
      gm_bit.push_back(bus_m.serial_out); gm_last.push_back(bus_m.serial_last);
    end
  end

  function automatic logic [WIDTH-1:0] word_l(input int k);
    logic [WIDTH-1:0] w = 'x;
    for (int i = 0; i < WIDTH; i++)
      if (k*WIDTH+i < gl_bit.size()) w[i] = gl_bit[k*WIDTH+i];
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] word_m(input int k);
    logic [WIDTH-1:0] w = 'x;
    for (int i = 0; i < WIDTH; i++)
      if (k*WIDTH+i < gm_bit.size()) w[WIDTH-1-i] = gm_bit[k*WIDTH+i];
    return w;
  endfunction

  function automatic int nlast_l();
    int n = 0;
    foreach (gl_last[i]) if (gl_last[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int span_l();
    if (gl_cyc.size() < 2) return -1;
    return gl_cyc[gl_cyc.size()-1] - gl_cyc[0];
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_got();
    gl_bit.delete(); gl_last.delete(); gl_cyc.delete();
    gm_bit.delete(); gm_last.delete();
  endtask

  task automatic put(input logic [WIDTH-1:0] w);
    din = w; wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  logic [WIDTH-1:0] words [5];
  logic [7:0]       first8;
  int               ones;

  initial begin
    rst_in = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    step(); step();
    rst_in = 1'b0;
    chk("reset_input_rdy",  {63'd0, bus_l.input_rdy},  64'd1);
    chk("reset_output_rdy", {63'd0, bus_m.output_rdy}, 64'd0);
    chk("reset_level",      64'(bus_l.fifo_level),     64'd0);

    // single word, LSB first on dut_l
    clear_got();
    put(32'hA5A5_0F0F);
    chk("t2_rdy_after_write", {63'd0, bus_l.output_rdy}, 64'd0);
    step();
    chk("t2_rdy_after_load",  {63'd0, bus_l.output_rdy}, 64'd1);
    rd = 1'b1;
    repeat (32) step();
    rd = 1'b0;
    step();
    for (int i = 0; i < 8; i++) first8[i] = (i < gl_bit.size()) ? gl_bit[i] : 1'bx;
    chk("t2_nbits",      64'(gl_bit.size()), 64'd32);
    chk("t2_first8",     64'(first8),        64'h0F);
    chk("t2_word_lsb",   64'(word_l(0)),     64'hA5A5_0F0F);
    chk("t2_word_msb",   64'(word_m(0)),     64'hA5A5_0F0F);
    chk("t2_nlast",      64'(nlast_l()),     64'd1);
    chk("t2_last_pos",   {63'd0, (gl_last.size() == 32) ? gl_last[31] : 1'b0}, 64'd1);
    chk("t2_rdy_done",   {63'd0, bus_l.output_rdy}, 64'd0);

    // MSB-first pattern; reads requested before data is ready have no effect
    clear_got();
    put(32'h8000_0001);
    rd = 1'b1;
    repeat (34) step();
    rd = 1'b0;
    step();
    ones = 0;
    for (int i = 1; i < 31; i++) if (i < gm_bit.size() && gm_bit[i] !== 1'b0) ones++;
    chk("t3_nbits",   64'(gm_bit.size()), 64'd32);
    chk("t3_first",   {63'd0, (gm_bit.size() > 0) ? gm_bit[0] : 1'bx}, 64'd1);
    chk("t3_middle",  64'(ones), 64'd0);
    chk("t3_lastbit", {63'd0, (gm_bit.size() == 32) ? gm_bit[31] : 1'bx}, 64'd1);
    chk("t3_lastflg", {63'd0, (gm_last.size() == 32) ? gm_last[31] : 1'bx}, 64'd1);

    // fill to full with read held low, then drain back-to-back
    clear_got();
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002; words[2] = 32'hF0F0_3333;
    words[3] = 32'h0000_0004; words[4] = 32'hFFFF_FFFE;
    for (int k = 0; k < 5; k++) put(words[k]);
    chk("t4_level_full", 64'(bus_l.fifo_level), 64'd4);
    chk("t4_input_rdy",  {63'd0, bus_l.input_rdy},  64'd0);
    chk("t4_output_rdy", {63'd0, bus_l.output_rdy}, 64'd1);
    put(32'hDEAD_BEEF);
    chk("t4_level_after_drop", 64'(bus_m.fifo_level), 64'd4);
    rd = 1'b1;
    repeat (160) step();
    rd = 1'b0;
    step();
    chk("t4_nbits", 64'(gl_bit.size()), 64'd160);
    chk("t4_span",  64'(span_l()),      64'd159);
    chk("t4_nlast", 64'(nlast_l()),     64'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_word%0d_lsb", k), 64'(word_l(k)), 64'(words[k]));
      chk($sformatf("t4_word%0d_msb", k), 64'(word_m(k)), 64'(words[k]));
    end
    chk("t4_empty_after", {63'd0, bus_l.output_rdy}, 64'd0);

    // read requested every other cycle
    clear_got();
    put(32'hC3C3_5A5A);
    for (int i = 0; i < 66; i++) begin
      rd = i[0];
      step();
    end
    rd = 1'b0;
    step();
    chk("t5_nbits",    64'(gl_bit.size()), 64'd32);
    chk("t5_span",     64'(span_l()),      64'd62);
    chk("t5_word_lsb", 64'(word_l(0)),     64'hC3C3_5A5A);
    chk("t5_word_msb", 64'(word_m(0)),     64'hC3C3_5A5A);

    // flush mid-word with two words queued; a simultaneous write is dropped
    put(32'hAAAA_AAAA); put(32'h5555_5555); put(32'h1234_5678);
    rd = 1'b1;
    repeat (10) step();
    rd = 1'b0;
    flush = 1'b1; wr = 1'b1; din = 32'hBAD0_BAD0;
    step();
    flush = 1'b0; wr = 1'b0;
    chk("t6_output_rdy", {63'd0, bus_l.output_rdy},   64'd0);
    chk("t6_level",      64'(bus_l.fifo_level),       64'd0);
    chk("t6_valid",      {63'd0, bus_m.serial_valid}, 64'd0);
    step();
    chk("t6_no_load",    {63'd0, bus_m.output_rdy},   64'd0);
    clear_got();
    put(32'h0000_FFFF);
    rd = 1'b1;
    repeat (34) step();
    rd = 1'b0;
    step();
    chk("t6_nbits",    64'(gl_bit.size()), 64'd32);
    chk("t6_word_lsb", 64'(word_l(0)),     64'h0000_FFFF);
    chk("t6_word_msb", 64'(word_m(0)),     64'h0000_FFFF);

    // reset held two cycles mid-stream
    put(32'hFFFF_FFFF); put(32'hFFFF_FFFF);
    rd = 1'b1;
    repeat (8) step();
    rst_in = 1'b1;
    step(); step();
    rst_in = 1'b0; rd = 1'b0;
    chk("t1_input_rdy",  {63'd0, bus_l.input_rdy},    64'd1);
    chk("t1_output_rdy", {63'd0, bus_l.output_rdy},   64'd0);
    chk("t1_serial_out", {63'd0, bus_m.serial_out},   64'd0);
    chk("t1_valid",      {63'd0, bus_l.serial_valid}, 64'd0);
    chk("t1_last",       {63'd0, bus_l.serial_last},  64'd0);
    chk("t1_level",      64'(bus_m.fifo_level),       64'd0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end
endmodule
